quad_encoder_gen: RTL and testbench



---
 rtl/quad_encoder_gen_if.sv | 27 ++
 rtl/quad_encoder_gen.sv | 91 +++++++++
 tb/tb_quad_encoder_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_gen_if.sv
// rtl/quad_encoder_gen_if.sv - command and quadrature-output bundle for quad_encoder_gen
interface quad_encoder_gen_if #(
  parameter int PERIOD_W = 16,
  parameter int STEPS_W  = 16,
  parameter int POS_W    = 16
);
  logic                start;
  logic                dir;
  logic [STEPS_W-1:0]  steps;
  logic [PERIOD_W-1:0] half_period;
  logic                stop;
  logic                quadA;
  logic                quadB;
  logic                busy;
  logic                done;
  logic [POS_W-1:0]    position;

  modport master (
    output start, dir, steps, half_period, stop,
    input  quadA, quadB, busy, done, position
  );

  modport slave (
    input  start, dir, steps, half_period, stop,
    output quadA, quadB, busy, done, position
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature A/B pulse-train generator with signed edge position
module quad_encoder_gen #(
  parameter int PERIOD_W = 16,
  parameter int STEPS_W  = 16,
  parameter int POS_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  quad_encoder_gen_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] period_r;
  logic [PERIOD_W-1:0] hp_eff;
  logic [STEPS_W-1:0]  remaining;
  logic                dir_r;
  logic                a_r;
  logic                b_r;
  logic                busy_r;
  logic                done_r;
  logic [POS_W-1:0]    pos_r;

  always_comb begin
    hp_eff = bus.half_period;
    if (bus.half_period == '0)
      hp_eff = PERIOD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      period_r  <= '0;
      remaining <= '0;
      dir_r     <= 1'b0;
      a_r       <= 1'b0;
      b_r       <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pos_r     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.steps != '0) begin
              dir_r     <= bus.dir;
              remaining <= bus.steps;
              period_r  <= hp_eff;
              timer     <= hp_eff;
              busy_r    <= 1'b1;
              state     <= RUN;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          // stop takes priority over an edge falling due in the same cycle
          if (bus.stop) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (timer == PERIOD_W'(1)) begin
            // forward: A_new = ~B_old, B_new = A_old; reverse is the mirror step
            a_r       <= dir_r ? ~b_r : b_r;
            b_r       <= dir_r ? a_r : ~a_r;
            pos_r     <= dir_r ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
            remaining <= remaining - STEPS_W'(1);
            timer     <= period_r;
            if (remaining == STEPS_W'(1)) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            timer <= timer - PERIOD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quadA    = a_r;
  assign bus.quadB    = b_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.position = pos_r;
endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - directed vector bench for quad_encoder_gen
module tb_quad_encoder_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_q = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dec_count = 0;
  int   gray_err = 0;
  logic [1:0] prev_ab = 2'b00;

  always #5 clk = ~clk;

  quad_encoder_gen_if #(.PERIOD_W(16), .STEPS_W(16), .POS_W(16)) bus();

  quad_encoder_gen #(.PERIOD_W(16), .STEPS_W(16), .POS_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference decoder: forward when A_new ^ B_old is 1, reverse otherwise
  always @(posedge clk) rst_q <= reset;
  always @(negedge clk) begin
    if (rst_q) begin
      prev_ab = {bus.quadA, bus.quadB};
    end else if ({bus.quadA, bus.quadB} != prev_ab) begin
      if (bus.quadA != prev_ab[1] && bus.quadB != prev_ab[0])
        gray_err = gray_err + 1;
      else if (bus.quadA ^ prev_ab[0])
        dec_count = dec_count + 1;
      else
        dec_count = dec_count - 1;
      prev_ab = {bus.quadA, bus.quadB};
    end
  end

  typedef struct {
    logic        do_reset;
    logic        dir;
    int          steps;
    int          hp;
    logic [1:0]  exp_ab;
    logic [15:0] exp_pos;
    int          exp_cycles;
    int          exp_first;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic run_cmd(input logic d, input int s, input int h, input int bound,
                         output int cyc, output int first, output int busy_drops);
    logic [1:0] ab0;
    bus.dir = d;
    bus.steps = s[15:0];
    bus.half_period = h[15:0];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ab0 = {bus.quadA, bus.quadB};
    cyc = 0;
    first = -1;
    busy_drops = 0;
    while (cyc < bound) begin
      tick();
      cyc++;
      if (first < 0 && {bus.quadA, bus.quadB} != ab0) first = cyc;
      if (bus.done) break;
      if (!bus.busy) busy_drops++;
    end
  endtask

  initial begin
    int cyc, first, drops, d0, done_seen;
    logic [1:0] ab_hold;
    logic [15:0] pos_hold;

    tbl[0] = '{1'b1, 1'b1, 8, 4, 2'b00, 16'd8,    32, 4};
    tbl[1] = '{1'b1, 1'b0, 6, 3, 2'b11, 16'hFFFA, 18, 3};
    tbl[2] = '{1'b0, 1'b1, 3, 0, 2'b10, 16'hFFFD, 3,  1};
    tbl[3] = '{1'b0, 1'b0, 5, 2, 2'b00, 16'hFFF8, 10, 2};
    tbl[4] = '{1'b0, 1'b1, 1, 7, 2'b10, 16'hFFF9, 7,  7};

    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.dir = 1'b0;
    bus.steps = '0;
    bus.half_period = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("reset_ab", {30'd0, bus.quadA, bus.quadB}, 32'd0);
    check("reset_pos", {16'd0, bus.position}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].do_reset) do_reset();
      d0 = dec_count;
      run_cmd(tbl[i].dir, tbl[i].steps, tbl[i].hp, 200, cyc, first, drops);
      check($sformatf("row%0d_cycles", i), cyc, tbl[i].exp_cycles);
      check($sformatf("row%0d_first_edge", i), first, tbl[i].exp_first);
      check($sformatf("row%0d_busy_gaps", i), drops, 0);
      check($sformatf("row%0d_done", i), {31'd0, bus.done}, 32'd1);
      check($sformatf("row%0d_busy_end", i), {31'd0, bus.busy}, 32'd0);
      check($sformatf("row%0d_ab", i), {30'd0, bus.quadA, bus.quadB}, {30'd0, tbl[i].exp_ab});
      check($sformatf("row%0d_pos", i), {16'd0, bus.position}, {16'd0, tbl[i].exp_pos});
      tick();
      check($sformatf("row%0d_decoder", i), dec_count - d0,
            tbl[i].dir ? tbl[i].steps : -tbl[i].steps);
      check($sformatf("row%0d_done_width", i), {31'd0, bus.done}, 32'd0);
    end

    // steps == 0: done next cycle with no edge
    ab_hold = {bus.quadA, bus.quadB};
    pos_hold = bus.position;
    bus.dir = 1'b1; bus.steps = '0; bus.half_period = 16'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero_done", {31'd0, bus.done}, 32'd1);
    check("zero_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("zero_done_drop", {31'd0, bus.done}, 32'd0);
    check("zero_ab", {30'd0, bus.quadA, bus.quadB}, {30'd0, ab_hold});

    // stop in IDLE is inert
    bus.stop = 1'b1;
    tick(); tick(); tick();
    bus.stop = 1'b0;
    check("idle_stop_pos", {16'd0, bus.position}, {16'd0, pos_hold});
    check("idle_stop_busy", {31'd0, bus.busy}, 32'd0);

    // start during RUN is ignored
    do_reset();
    bus.dir = 1'b1; bus.steps = 16'd4; bus.half_period = 16'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      if (cyc == 4) begin
        bus.start = 1'b1; bus.dir = 1'b0; bus.steps = 16'd1; bus.half_period = 16'd1;
      end
      if (cyc == 5) bus.start = 1'b0;
      tick();
      cyc++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    check("ignore_cycles", cyc, 12);
    check("ignore_pos", {16'd0, bus.position}, 32'd4);
    check("ignore_ab", {30'd0, bus.quadA, bus.quadB}, 32'd0);

    // abort coincident with the 3rd edge
    do_reset();
    bus.dir = 1'b1; bus.steps = 16'd100; bus.half_period = 16'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    check("abort_pre_pos", {16'd0, bus.position}, 32'd2);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_pos", {16'd0, bus.position}, 32'd2);
    check("abort_ab", {30'd0, bus.quadA, bus.quadB}, 32'd3);
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_hold_ab", {30'd0, bus.quadA, bus.quadB}, 32'd3);

    // position wrap and Gray continuity across commands
    do_reset();
    run_cmd(1'b1, 65535, 0, 70000, cyc, first, drops);
    check("wrap1_cycles", cyc, 65535);
    check("wrap1_pos", {16'd0, bus.position}, 32'hFFFF);
    check("wrap1_ab", {30'd0, bus.quadA, bus.quadB}, 32'd1);
    run_cmd(1'b1, 2, 0, 20, cyc, first, drops);
    check("wrap2_pos", {16'd0, bus.position}, 32'd1);
    check("wrap2_ab", {30'd0, bus.quadA, bus.quadB}, 32'd2);
    run_cmd(1'b0, 1, 0, 20, cyc, first, drops);
    check("wrap3_pos", {16'd0, bus.position}, 32'd0);
    check("wrap3_ab", {30'd0, bus.quadA, bus.quadB}, 32'd0);
    tick();

    // reset mid-run
    bus.dir = 1'b1; bus.steps = 16'd10; bus.half_period = 16'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("midrst_pre_pos", {16'd0, bus.position}, 32'd2);
    check("midrst_pre_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ab", {30'd0, bus.quadA, bus.quadB}, 32'd0);
    check("midrst_pos", {16'd0, bus.position}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    tick(); tick(); tick();
    check("midrst_idle_ab", {30'd0, bus.quadA, bus.quadB}, 32'd0);

    check("gray_single_toggle", gray_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
